// File: rtl/sdatopa.sv
// sdatopa: serial-to-parallel receiver for the two-wire scl/sda link.
// Oversamples scl/sda on sclk, detects start/stop, shifts in a 4-bit
// MSB-first nibble and presents it with a one-cycle valid strobe.
// Optional macro SDATOPA_ONEHOT_EN builds the registered one-hot decode
// on outhigh; without it outhigh is tied to zero.
module sdatopa #(
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT     = 1024
) (
   input  logic        sclk,
   input  logic        rst,
   input  logic        scl,
   input  logic        sda,
   output logic [3:0]  data,
   output logic        valid,
   output logic        frame_err,
   output logic        busy,
   output logic [15:0] outhigh
);

   typedef enum logic [1:0] {IDLE, BIT, WAIT_STOP} state_t;

   localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

   logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
   logic                   scl_s, sda_s, scl_q, sda_q;
   logic                   scl_rise, scl_edge, start_ev, stop_ev;

   state_t      state, state_n;
   logic [2:0]  bcnt, bcnt_n;
   logic [3:0]  shreg, shreg_n, data_n;
   logic [15:0] tcnt, tcnt_n;
   logic        valid_n, err_n;

   assign scl_s = scl_sync[SYNC_STAGES-1];
   assign sda_s = sda_sync[SYNC_STAGES-1];

   // Synchronisers plus one delayed copy; reset to the idle bus level (high)
   always_ff @(posedge sclk) begin
      if (rst) begin
         scl_sync <= '1;
         sda_sync <= '1;
         scl_q    <= 1'b1;
         sda_q    <= 1'b1;
      end else begin
         scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
         sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda};
         scl_q    <= scl_s;
         sda_q    <= sda_s;
      end
   end

   // Start/stop need scl high in both samples, so an scl change always wins
   assign scl_rise = ~scl_q & scl_s;
   assign scl_edge = scl_q ^ scl_s;
   assign start_ev = scl_q & scl_s & sda_q & ~sda_s;
   assign stop_ev  = scl_q & scl_s & ~sda_q & sda_s;

   // Frame state machine: next state, shift register, timeout and strobes
   always_comb begin
      state_n = state;
      bcnt_n  = bcnt;
      shreg_n = shreg;
      tcnt_n  = tcnt;
      data_n  = data;
      valid_n = 1'b0;
      err_n   = 1'b0;
      case (state)
         IDLE: begin
            tcnt_n = '0;
            bcnt_n = '0;
            if (start_ev) begin
               state_n = BIT;
               shreg_n = '0;
            end
         end
         default: begin
            if (start_ev) begin
               // repeated start: restart the frame without flagging an error
               state_n = BIT;
               shreg_n = '0;
               bcnt_n  = '0;
               tcnt_n  = '0;
            end else if (stop_ev) begin
               state_n = IDLE;
               if (state == WAIT_STOP) begin
                  data_n  = shreg;
                  valid_n = 1'b1;
               end else begin
                  err_n = 1'b1;
               end
            end else if (scl_edge) begin
               tcnt_n = '0;
               // rises in WAIT_STOP are the transmitter's trailing bit
               if (scl_rise && state == BIT) begin
                  shreg_n = {shreg[2:0], sda_s};
                  bcnt_n  = bcnt + 3'd1;
                  if (bcnt == 3'd3) state_n = WAIT_STOP;
               end
            end else if (tcnt == TO_LAST) begin
               state_n = IDLE;
               err_n   = 1'b1;
            end else begin
               tcnt_n = tcnt + 16'd1;
            end
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge sclk) begin
      if (rst) begin
         state     <= IDLE;
         bcnt      <= '0;
         shreg     <= '0;
         tcnt      <= '0;
         data      <= 4'h0;
         valid     <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         state     <= state_n;
         bcnt      <= bcnt_n;
         shreg     <= shreg_n;
         tcnt      <= tcnt_n;
         data      <= data_n;
         valid     <= valid_n;
         frame_err <= err_n;
      end
   end

   assign busy = (state != IDLE);

`ifdef SDATOPA_ONEHOT_EN
   // One-hot decode, updated on the same edge as data
   always_ff @(posedge sclk) begin
      if (rst) outhigh <= 16'h0001;
      else     outhigh <= 16'h0001 << data_n;
   end
`else
   assign outhigh = 16'h0000;
`endif

endmodule

// File: tb/tb_sdatopa.sv
// tb_sdatopa: directed frames against a queue-based protocol model of
// sdatopa, compared every cycle, plus hand-computed literal checks.
module tb_sdatopa;

   localparam int S  = 2;
   localparam int TO = 16;
   localparam int PH = 4;
`ifdef SDATOPA_ONEHOT_EN
   localparam bit OH = 1'b1;
`else
   localparam bit OH = 1'b0;
`endif

   logic        sclk = 1'b0;
   logic        rst, scl, sda;
   logic [3:0]  data;
   logic        valid, frame_err, busy;
   logic [15:0] outhigh;

   int n_vec = 0, n_bad = 0;
   int n_valid = 0, n_err = 0;
   bit armed = 1'b0;

   sdatopa #(.SYNC_STAGES(S), .TIMEOUT(TO)) dut (
      .sclk(sclk), .rst(rst), .scl(scl), .sda(sda), .data(data),
      .valid(valid), .frame_err(frame_err), .busy(busy), .outhigh(outhigh)
   );

   always #5 sclk = ~sclk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Pin samples delayed through a history array; protocol kept as a
   // list of received bits plus an idle-cycle counter.
   logic hscl[S+1], hsda[S+1];
   logic q_bits[$];
   bit   in_frame;
   int   idle;
   logic [3:0] m_data;
   bit   m_valid, m_err;

   always @(posedge sclk) begin
      if (rst) begin
         for (int i = 0; i <= S; i++) begin hscl[i] = 1'b1; hsda[i] = 1'b1; end
         q_bits.delete();
         in_frame = 0; idle = 0; m_data = 4'h0; m_valid = 0; m_err = 0;
      end else begin
         logic cs, cq, ds, dq;
         cs = hscl[S-1]; cq = hscl[S]; ds = hsda[S-1]; dq = hsda[S];
         m_valid = 0; m_err = 0;
         if (cs && cq && dq && !ds) begin
            in_frame = 1; q_bits.delete(); idle = 0;
         end else if (in_frame) begin
            if (cs && cq && !dq && ds) begin
               if (q_bits.size() == 4) begin
                  m_data = {q_bits[0], q_bits[1], q_bits[2], q_bits[3]};
                  m_valid = 1;
               end else m_err = 1;
               in_frame = 0;
            end else if (cs != cq) begin
               idle = 0;
               if (cs && q_bits.size() < 4) q_bits.push_back(ds);
            end else if (idle == TO - 1) begin
               m_err = 1; in_frame = 0;
            end else idle++;
         end
         for (int i = S; i > 0; i--) begin hscl[i] = hscl[i-1]; hsda[i] = hsda[i-1]; end
         hscl[0] = scl; hsda[0] = sda;
      end
   end

   // Every-cycle compare against the model
   always @(negedge sclk) begin
      if (armed) begin
         chk("valid", valid, m_valid);
         chk("frame_err", frame_err, m_err);
         chk("busy", busy, in_frame);
         chk("data", data, m_data);
         chk("outhigh", outhigh, OH ? (16'h0001 << m_data) : 16'h0000);
         chk("excl", valid & frame_err, 1'b0);
         if (valid) n_valid++;
         if (frame_err) n_err++;
      end
   end

   // ---------------- stimulus ----------------
   task automatic hold(input int n);
      repeat (n) @(negedge sclk);
   endtask

   task automatic set(input logic c, input logic d);
      scl = c; sda = d; hold(PH);
   endtask

   task automatic start();
      set(0, 1); set(1, 1); set(1, 0);
   endtask

   task automatic bitx(input logic b);
      set(0, b); set(1, b); set(0, b);
   endtask

   task automatic send_bits(input logic [3:0] v, input int n);
      for (int i = n - 1; i >= 0; i--) bitx(v[i]);
   endtask

   task automatic stop();
      set(0, 0); set(1, 0); set(1, 1); hold(2);
   endtask

   initial begin
      int v0, e0, n;
      bit seen;
      rst = 1'b1; scl = 1'b1; sda = 1'b1;
      hold(3);
      armed = 1'b1;
      chk("rst_data", data, 4'h0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_oh", outhigh, OH ? 16'h0001 : 16'h0000);
      rst = 1'b0;
      hold(4);

      // single frame 1011
      v0 = n_valid; e0 = n_err;
      start(); send_bits(4'hB, 4); stop();
      chk("s1_data", data, 4'hB);
      chk("s1_nvalid", n_valid - v0, 1);
      chk("s1_oh", outhigh, OH ? 16'h0800 : 16'h0000);

      // back-to-back 0 then F
      v0 = n_valid; e0 = n_err;
      start(); send_bits(4'h0, 4); stop();
      chk("b2b_data0", data, 4'h0);
      start(); send_bits(4'hF, 4); stop();
      chk("b2b_data", data, 4'hF);
      chk("b2b_nvalid", n_valid - v0, 2);
      chk("b2b_nerr", n_err - e0, 0);
      chk("b2b_oh", outhigh, OH ? 16'h8000 : 16'h0000);

      // short frame
      v0 = n_valid; e0 = n_err;
      start(); send_bits(4'b0010, 2); stop();
      chk("short_nerr", n_err - e0, 1);
      chk("short_nvalid", n_valid - v0, 0);
      chk("short_data", data, 4'hF);
      chk("short_busy", busy, 1'b0);

      // repeated start
      v0 = n_valid; e0 = n_err;
      start(); send_bits(4'b0011, 2); start(); send_bits(4'h6, 4); stop();
      chk("rs_data", data, 4'h6);
      chk("rs_nvalid", n_valid - v0, 1);
      chk("rs_nerr", n_err - e0, 0);

      // timeout: start, 2 bits, then scl held high
      start(); bitx(1'b1); set(0, 0);
      scl = 1'b1;
      seen = 0; n = 0;
      for (int i = 1; i <= 100 && !seen; i++) begin
         @(posedge sclk); #1;
         if (frame_err) begin seen = 1; n = i; end
      end
      chk("to_seen", seen, 1'b1);
      chk("to_cycles", n, S + 17);
      chk("to_busy", busy, 1'b0);
      @(negedge sclk);
      set(1, 1); hold(4);

      // reset mid-frame after 3 bits
      start(); send_bits(4'b0101, 3);
      v0 = n_valid; e0 = n_err;
      rst = 1'b1; @(negedge sclk); rst = 1'b0;
      chk("mr_data", data, 4'h0);
      chk("mr_busy", busy, 1'b0);
      chk("mr_oh", outhigh, OH ? 16'h0001 : 16'h0000);
      set(1, 1); hold(6);
      chk("mr_npulse", (n_valid - v0) + (n_err - e0), 0);
      start(); send_bits(4'h9, 4); stop();
      chk("mr_data9", data, 4'h9);
      chk("mr_nvalid", n_valid - v0, 1);
      chk("mr_nerr", n_err - e0, 0);
      hold(4);

      armed = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/sdatopa.md
# sdatopa

Serial-to-parallel receiver that sits directly downstream of the parallel-to-serial SDA transmitter. It oversamples the two-wire `scl`/`sda` link with the system clock and recognises the start condition. It then shifts in four data bits MSB-first, qualifies the frame on the stop condition, and presents the nibble as parallel data with a one-cycle valid strobe. An optional 16-bit one-hot decode drives the LED/display bank.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: synchroniser depth on `scl` and `sda`. Legal range is 2 to 4.
- `TIMEOUT`, default 1024: number of `sclk` cycles with no `scl` edge inside a frame before the frame is aborted. Legal range is 16 to 65535.

Ports:
- `sclk` input, 1 bit: system clock. All logic is on its rising edge.
- `rst` input, 1 bit: reset, synchronous and active-high.
- `scl` input, 1 bit: serial clock from the transmitter. It is asynchronous to `sclk`.
- `sda` input, 1 bit: serial data from the transmitter. It is asynchronous to `sclk`.
- `data` output, 4 bits: last successfully received nibble.
- `valid` output, 1 bit: one-cycle pulse when `data` updates.
- `frame_err` output, 1 bit: one-cycle pulse when a frame is aborted.
- `busy` output, 1 bit: high while a frame is in progress.
- `outhigh` output, 16 bits: one-hot decode of `data`. See Configuration.

## Operation
- **Synchronisation:** `scl` and `sda` each pass through `SYNC_STAGES` flops. A further register holds the previous synchronised value (`scl_q`, `sda_q`).
- **Event definitions** (all on synchronised signals):
  - scl_rise: `scl_q`=0 and `scl_s`=1.
  - start: `scl_q`=1, `scl_s`=1, `sda_q`=1, `sda_s`=0.
  - stop: `scl_q`=1, `scl_s`=1, `sda_q`=0, `sda_s`=1.
  - Start and stop require `scl` high in both samples. If `scl` and `sda` change in the same sample, only scl_rise is recognised, and the bit captured is the new `sda_s`.
- **State machine:**
  - IDLE: `busy`=0, bit counter=0. A start moves to BIT. All other events are ignored.
  - BIT: on scl_rise, shift `sda_s` into `shreg[3:0]` MSB-first and increment the bit counter. When the 4th bit is captured, go to WAIT_STOP.
  - WAIT_STOP: scl_rise events are ignored, so the transmitter's trailing low bit is tolerated. A stop loads `data`<=`shreg`, pulses `valid`, and goes to IDLE.
  - Start in BIT or WAIT_STOP (repeated start): clear `shreg` and the counter, stay in or re-enter BIT, and set no error flag.
  - Stop in BIT (fewer than 4 bits): pulse `frame_err`, leave `data` unchanged, go to IDLE.
  - Timeout: a 16-bit counter clears on every scl edge (rise or fall) and on entry to BIT. It increments each cycle in BIT or WAIT_STOP. When it reaches `TIMEOUT`-1, pulse `frame_err` and go to IDLE.
- **Register behaviour:**
  - `valid` and `frame_err` are never high in the same cycle.
  - `data` holds its value between frames.
- **Reset values:** `data`=4'h0, `valid`=0, `frame_err`=0, `busy`=0, `outhigh`=16'h0001 (with the macro defined), state=IDLE, synchroniser flops=1 (idle bus level).
- **Reset mid-frame:** the partial frame is discarded with no `valid` and no `frame_err`. The next frame is accepted only after a fresh start.

## Timing
- **Edge-detection latency:** a pin transition first sampled on `sclk` edge k is seen as an event at edge k+`SYNC_STAGES`. Registered outputs update on that edge.
- **`valid`:** high for exactly one cycle, starting `SYNC_STAGES` cycles after the stop-condition `sda` rise is first sampled. `data` is stable from that same edge onward.
- **`busy`:** rises on the edge where the start event is registered. Falls on the same edge as `valid` or `frame_err`.
- **`outhigh`:** registered, and updates on the same edge as `data`.
- **Minimum `scl` timing:** high and low phases of at least `SYNC_STAGES`+1 `sclk` cycles each. The transmitter's `scl`, which runs at `sclk`/2, does not meet this when both share a clock. In that system the transmitter's `scl` must be slowed, or this block must be clocked at 4x or faster.

## Configuration
- `SDATOPA_ONEHOT_EN` defined: `outhigh` = 16'b1 << `data`, registered. It is 16'h0001 after reset.
- `SDATOPA_ONEHOT_EN` undefined: no decoder logic is built, and `outhigh` is tied to 16'h0000. All other behaviour is identical.

## Test plan
- **Single frame:** reset, then start, bits 1,0,1,1, a trailing low bit, then stop. Expect `data`=4'hB, one `valid` pulse, and `outhigh`=16'h0800 (macro defined).
- **Back-to-back frames:** send 4'h0 then 4'hF. Expect two `valid` pulses, `data`=4'hF, `outhigh`=16'h8000, and `frame_err` never high.
- **Short frame:** start, bits 1,0, then stop. Expect a `frame_err` pulse, no `valid`, and `data` kept at its previous value.
- **Repeated start:** start, bits 1,1, start, then bits 0,1,1,0 and stop. Expect `data`=4'h6, one `valid`, and no `frame_err`.
- **Timeout:** with `TIMEOUT`=16, send start, 2 bits, then hold `scl` high and `sda` steady. Expect `frame_err` exactly 16 cycles after the last scl edge is registered, then `busy`=0.
- **Reset mid-frame:** assert `rst` for one cycle after 3 bits. Expect all outputs at reset values, no pulses, and a following complete frame of 4'h9 accepted normally.
